// File: rtl/sprite_pkg.sv
// Shared types for the sprite engine: life-cycle state, colour word and a
// coordinate widening helper so all position arithmetic happens in 11 bits.
package sprite_pkg;

   typedef enum logic [1:0] {
      ALIVE = 2'd0,
      HIT   = 2'd1,
      DEAD  = 2'd2
   } sprite_state_t;

   typedef logic [23:0] color_t;

   localparam int COORD_W = 11;

   function automatic logic [COORD_W-1:0] ext11(input logic [9:0] v);
      return {1'b0, v};
   endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Screen coordinate to sprite ROM address translation with optional mirroring,
// plus the two-stage in-box/visibility delay that lines up with ROM read data.
module sprite_addr_gen
   import sprite_pkg::*;
#(
   parameter int SPRITE_W = 36,
   parameter int SPRITE_H = 40,
   parameter int ADDR_W   = $clog2(SPRITE_W * SPRITE_H)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic [9:0]        pos_x,
   input  logic [9:0]        pos_y,
   input  logic              flip,
   input  logic              visible,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              in_box_d2,
   output logic              visible_d2
);

   localparam logic [COORD_W-1:0] W11 = COORD_W'(SPRITE_W);
   localparam logic [COORD_W-1:0] H11 = COORD_W'(SPRITE_H);
   localparam logic [COORD_W-1:0] WM1 = COORD_W'(SPRITE_W - 1);

   logic [COORD_W-1:0] x_s;
   logic [COORD_W-1:0] y_s;
   logic [COORD_W-1:0] px_s;
   logic [COORD_W-1:0] py_s;
   logic [COORD_W-1:0] col_s;
   logic [COORD_W-1:0] row_s;
   logic [COORD_W-1:0] col_eff_s;
   logic               in_box_s;
   logic [ADDR_W-1:0]  addr_s;
   logic               in_box_d1_r;
   logic               visible_d1_r;

   // Box test and address arithmetic; row/col only meaningful when in_box_s
   always_comb begin
      x_s      = ext11(DrawX);
      y_s      = ext11(DrawY);
      px_s     = ext11(pos_x);
      py_s     = ext11(pos_y);
      col_s    = x_s - px_s;
      row_s    = y_s - py_s;
      in_box_s = (x_s >= px_s) && (x_s < px_s + W11) &&
                 (y_s >= py_s) && (y_s < py_s + H11);
      if (flip) begin
         col_eff_s = WM1 - col_s;
      end else begin
         col_eff_s = col_s;
      end
      addr_s = ADDR_W'(row_s) * ADDR_W'(W11) + ADDR_W'(col_eff_s);
   end

   // Address register (holds outside the box) and the alignment delay line
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rom_addr     <= '0;
         in_box_d1_r  <= 1'b0;
         visible_d1_r <= 1'b0;
         in_box_d2    <= 1'b0;
         visible_d2   <= 1'b0;
      end else begin
         if (in_box_s) begin
            rom_addr <= addr_s;
         end
         in_box_d1_r  <= in_box_s;
         visible_d1_r <= visible;
         in_box_d2    <= in_box_d1_r;
         visible_d2   <= visible_d1_r;
      end
   end

endmodule

// File: rtl/sprite_engine.sv
// Per-sprite position, life cycle (ALIVE/HIT blink/DEAD) and pixel rendering
// from an external synchronous ROM; output lags DrawX/DrawY by three cycles.
module sprite_engine
   import sprite_pkg::*;
#(
   parameter int     SPRITE_W   = 36,
   parameter int     SPRITE_H   = 40,
   parameter int     START_X    = 320,
   parameter int     START_Y    = 420,
   parameter int     X_MIN      = 20,
   parameter int     X_MAX      = 563,
   parameter int     X_STEP     = 5,
   parameter int     HIT_FRAMES = 32,
   parameter int     FLIP_EN    = 1,
   parameter color_t KEY_COLOR  = 24'hFF00FF,
   parameter int     ADDR_W     = $clog2(SPRITE_W * SPRITE_H)
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              frame_tick,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              move_left,
   input  logic              move_right,
   input  logic              hit,
   input  logic              respawn,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [23:0]       rom_data,
   output logic              sprite_on,
   output logic [23:0]       sprite_color,
   output logic [9:0]        pos_x,
   output logic [9:0]        pos_y,
   output logic              alive
);

   sprite_state_t state_r;
   sprite_state_t state_n_s;
   logic [7:0]    hit_cnt_r;
   logic [7:0]    cnt_n_s;
   logic [9:0]    pos_n_s;
   logic          facing_left_r;
   logic          face_n_s;
   logic [10:0]   px11_s;
   logic          visible_s;
   logic          flip_s;
   logic          in_box_d2_s;
   logic          visible_d2_s;

   assign pos_y = 10'(START_Y);

   // Next-state, motion and blink counter; hit has priority over a same-cycle tick
   always_comb begin
      state_n_s = state_r;
      cnt_n_s   = hit_cnt_r;
      pos_n_s   = pos_x;
      face_n_s  = facing_left_r;
      px11_s    = ext11(pos_x);
      case (state_r)
         ALIVE: begin
            if (hit) begin
               state_n_s = HIT;
               cnt_n_s   = 8'(HIT_FRAMES);
            end else if (frame_tick && move_left && !move_right) begin
               if (px11_s < 11'(X_MIN + X_STEP)) begin
                  pos_n_s = 10'(X_MIN);
               end else begin
                  pos_n_s = pos_x - 10'(X_STEP);
               end
               face_n_s = 1'b1;
            end else if (frame_tick && move_right && !move_left) begin
               if (px11_s > 11'(X_MAX - X_STEP)) begin
                  pos_n_s = 10'(X_MAX);
               end else begin
                  pos_n_s = pos_x + 10'(X_STEP);
               end
               face_n_s = 1'b0;
            end else begin
               state_n_s = ALIVE;
            end
         end
         HIT: begin
            if (frame_tick) begin
               if (hit_cnt_r <= 8'd1) begin
                  cnt_n_s   = 8'd0;
                  state_n_s = DEAD;
               end else begin
                  cnt_n_s = hit_cnt_r - 8'd1;
               end
            end else begin
               state_n_s = HIT;
            end
         end
         DEAD: begin
            if (respawn) begin
               state_n_s = ALIVE;
               pos_n_s   = 10'(START_X);
               face_n_s  = 1'b0;
               cnt_n_s   = 8'd0;
            end else begin
               state_n_s = DEAD;
            end
         end
         default: begin
            state_n_s = ALIVE;
            cnt_n_s   = 8'd0;
         end
      endcase
   end

   // Life-cycle and position registers
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_r       <= ALIVE;
         hit_cnt_r     <= 8'd0;
         pos_x         <= 10'(START_X);
         facing_left_r <= 1'b0;
         alive         <= 1'b1;
      end else begin
         state_r       <= state_n_s;
         hit_cnt_r     <= cnt_n_s;
         pos_x         <= pos_n_s;
         facing_left_r <= face_n_s;
         alive         <= (state_n_s == ALIVE);
      end
   end

   assign visible_s = (state_r == ALIVE) || ((state_r == HIT) && hit_cnt_r[2]);
   assign flip_s    = (FLIP_EN != 0) && facing_left_r;

   sprite_addr_gen #(
      .SPRITE_W (SPRITE_W),
      .SPRITE_H (SPRITE_H),
      .ADDR_W   (ADDR_W)
   ) u_addr_gen (
      .Clk        (Clk),
      .Reset      (Reset),
      .DrawX      (DrawX),
      .DrawY      (DrawY),
      .pos_x      (pos_x),
      .pos_y      (pos_y),
      .flip       (flip_s),
      .visible    (visible_s),
      .rom_addr   (rom_addr),
      .in_box_d2  (in_box_d2_s),
      .visible_d2 (visible_d2_s)
   );

   // Pixel output stage with transparency key
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sprite_on    <= 1'b0;
         sprite_color <= 24'h000000;
      end else if (in_box_d2_s && visible_d2_s && (rom_data != KEY_COLOR)) begin
         sprite_on    <= 1'b1;
         sprite_color <= rom_data;
      end else begin
         sprite_on    <= 1'b0;
         sprite_color <= 24'h000000;
      end
   end

endmodule
